ddc_lo_seq: RTL
===============

Name: ddc_lo_seq

Overview:
Sequencer for the DDC mixer datapath. It arms and captures one period of the DDS carrier into the cos/sin LO tables, starting at a fixed trigger phase. It then steps the LO read address once per accepted I/Q sample, keeping it aligned to input frames via tlast. It also produces delay-matched valid/last for the fixed-latency multiply/add pipeline feeding the output FIFOs.

Parameters:
FRAME_LEN, 680, LO table depth and samples per frame (interpolation-by-2 setting)
TRIG_PHASE, -6559, signed 16-bit DDS phase value that starts table capture
PIPE_LAT, 3, cycles from sample acceptance to mixer result valid (mult + add stages)
AW, 10, table address width; must satisfy 2^AW >= FRAME_LEN

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; (re)arms LO table capture
phase_valid  in  1  DDS phase output valid
phase  in  16  DDS phase, signed
tbl_we  out  1  write strobe to cos and sin tables (DDS data written same cycle)
tbl_waddr  out  AW  table write address, 0-based
tbl_ready  out  1  table capture complete; mixer may run
s_tvalid  in  1  input I/Q sample valid (I and Q lanes already aligned)
s_tlast  in  1  last sample of input frame
s_tready  out  1  sample accept
m_tready  in  1  output FIFO ready (I and Q FIFOs ANDed upstream)
tbl_raddr  out  AW  LO table read address for the current sample
pipe_valid  out  1  mixer result valid, to output FIFO s_axis_tvalid
pipe_last  out  1  mixer result last, to output FIFO s_axis_tlast
frame_err  out  1  sticky frame/LO misalignment flag
frame_cnt  out  16  count of accepted frames, wraps at 2^16

Behaviour:
- Reset (async, aresetn=0): state=IDLE. All outputs 0: tbl_we, tbl_waddr, tbl_ready, s_tready, tbl_raddr, pipe shift register, frame_err, frame_cnt.
- States: IDLE, ARM, CAPTURE, RUN. All transitions are registered.
- IDLE: start=1 -> ARM.
- ARM: the first cycle with phase_valid=1 and phase==TRIG_PHASE (signed compare) -> CAPTURE, tbl_waddr=0.
- CAPTURE: tbl_we=1 every cycle; tbl_waddr increments 0..FRAME_LEN-1.
  - Exactly FRAME_LEN writes are issued; phase_valid is ignored.
  - After the write at FRAME_LEN-1 -> RUN, with tbl_ready=1 from the next cycle. tbl_we=0 outside CAPTURE.
- RUN:
  - s_tready = tbl_ready & m_tready (combinational). Accept = s_tvalid & s_tready.
  - tbl_raddr is registered and addresses the sample being accepted this cycle.
  - On accept, tbl_raddr increments and wraps FRAME_LEN-1 -> 0.
- Frame alignment, on accept:
  - s_tlast=1 with tbl_raddr==FRAME_LEN-1: normal wrap; frame_cnt+1.
  - s_tlast=1 with tbl_raddr!=FRAME_LEN-1: frame_err<=1; tbl_raddr<=0 (resync); frame_cnt+1.
  - s_tlast=0 with tbl_raddr==FRAME_LEN-1: frame_err<=1; wrap to 0; frame_cnt unchanged.
- frame_err clears only on reset or start.
- Pipeline:
  - Valid and last shift registers of PIPE_LAT stages, shifting every cycle (the mixer pipeline never stalls).
  - Stage 0 input = accept and (accept & s_tlast).
  - pipe_valid/pipe_last = stage PIPE_LAT-1, i.e. exactly PIPE_LAT cycles after accept.
  - Downstream FIFO must keep >= PIPE_LAT entries of headroom when asserting m_tready.
- start in ARM/CAPTURE/RUN: -> ARM next cycle. tbl_ready<=0, s_tready drops, tbl_raddr<=0, tbl_we<=0, frame_err<=0.
  - Capture restarts at address 0 on the next trigger.
  - Samples already in the pipe shift register still drain to pipe_valid.
- start coincident with the trigger match: start wins; stay ARM, match again on a later trigger.
- Before tbl_ready, s_tready=0 regardless of m_tready; no samples are accepted.

Test Plan:
- Reset, start, phase ramp hitting -6559 at cycle 10 -> tbl_we high for exactly 680 cycles, tbl_waddr 0..679, tbl_ready=1 one cycle after the write at 679.
- After capture, 2 frames of 680 samples with tlast on each 680th, s_tvalid/m_tready continuous -> tbl_raddr 0..679,0..679; pipe_valid 3 cycles after each accept; pipe_last at 3 cycles after each tlast; frame_cnt=2; frame_err=0.
- Random s_tvalid gaps and m_tready deasserted 50 cycles mid-frame -> s_tready follows m_tready, no address advance while stalled, sequence continues gap-free.
- Early tlast at tbl_raddr=400 -> frame_err=1, next accepted sample uses tbl_raddr=0, frame_cnt increments. Separately, missing tlast at address 679 -> frame_err=1, wrap to 0.
- start pulse mid-RUN at tbl_raddr=200 with 3 samples in flight -> s_tready=0 next cycle, 3 pipe_valid pulses still emitted, tbl_ready=0, frame_err cleared, recapture on the next trigger.
- aresetn asserted mid-CAPTURE at tbl_waddr=300 -> all outputs 0 immediately (asynchronously); after release, state IDLE and no tbl_we until start plus trigger.

Source files
------------

// File: rtl/ddc_lo_seq.sv
// DDC LO sequencer: captures one DDS carrier period into cos/sin tables, then steps the read address per accepted sample.
// Mixer valid/last appear exactly PIPE_LAT cycles after accept; s_tready follows m_tready once the table is captured.
module ddc_lo_seq #(
  parameter int FRAME_LEN  = 680,
  parameter int TRIG_PHASE = -6559,
  parameter int PIPE_LAT   = 3,
  parameter int AW         = 10
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic          phase_valid,
  input  logic [15:0]   phase,
  output logic          tbl_we,
  output logic [AW-1:0] tbl_waddr,
  output logic          tbl_ready,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  input  logic          m_tready,
  output logic [AW-1:0] tbl_raddr,
  output logic          pipe_valid,
  output logic          pipe_last,
  output logic          frame_err,
  output logic [15:0]   frame_cnt
);

  localparam logic [AW-1:0]      LP_LAST = AW'(FRAME_LEN - 1);
  localparam logic [AW-1:0]      LP_ONE  = AW'(1);
  localparam logic signed [15:0] LP_TRIG = 16'(TRIG_PHASE);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPTURE, ST_RUN} state_t;

  state_t              r_state;
  logic                r_tbl_we;
  logic [AW-1:0]       r_tbl_waddr;
  logic                r_tbl_ready;
  logic [AW-1:0]       r_tbl_raddr;
  logic                r_frame_err;
  logic [15:0]         r_frame_cnt;
  logic [PIPE_LAT-1:0] r_pv;
  logic [PIPE_LAT-1:0] r_pl;

  logic w_trig;
  logic w_accept;

  assign w_trig   = phase_valid && ($signed(phase) == LP_TRIG);
  assign s_tready = r_tbl_ready & m_tready;
  assign w_accept = s_tvalid & s_tready;

  assign tbl_we     = r_tbl_we;
  assign tbl_waddr  = r_tbl_waddr;
  assign tbl_ready  = r_tbl_ready;
  assign tbl_raddr  = r_tbl_raddr;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;
  assign pipe_valid = r_pv[PIPE_LAT-1];
  assign pipe_last  = r_pl[PIPE_LAT-1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_tbl_we    <= 1'b0;
      r_tbl_waddr <= '0;
      r_tbl_ready <= 1'b0;
      r_tbl_raddr <= '0;
      r_frame_err <= 1'b0;
    end else if (start) begin
      // start wins over a coincident trigger; capture restarts from scratch
      r_state     <= ST_ARM;
      r_tbl_we    <= 1'b0;
      r_tbl_ready <= 1'b0;
      r_tbl_raddr <= '0;
      r_frame_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_ARM: begin
          if (w_trig) begin
            r_state     <= ST_CAPTURE;
            r_tbl_we    <= 1'b1;
            r_tbl_waddr <= '0;
          end
        end
        ST_CAPTURE: begin
          if (r_tbl_waddr == LP_LAST) begin
            r_state     <= ST_RUN;
            r_tbl_we    <= 1'b0;
            r_tbl_ready <= 1'b1;
          end else begin
            r_tbl_waddr <= r_tbl_waddr + LP_ONE;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (s_tlast) begin
              // an early tlast resyncs the LO to the frame start
              r_tbl_raddr <= '0;
              if (r_tbl_raddr != LP_LAST) r_frame_err <= 1'b1;
            end else if (r_tbl_raddr == LP_LAST) begin
              r_tbl_raddr <= '0;
              r_frame_err <= 1'b1;
            end else begin
              r_tbl_raddr <= r_tbl_raddr + LP_ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_frame_cnt <= '0;
    end else if (w_accept && s_tlast) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // mixer pipeline never stalls, so valid/last simply shift every cycle
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_pv <= '0;
      r_pl <= '0;
    end else begin
      r_pv[0] <= w_accept;
      r_pl[0] <= w_accept & s_tlast;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
      end
    end
  end

endmodule
